// File: rtl/fir_mac_seq.sv
// Sequencer/MAC stage behind the FIR addressable shift register: accepts a sample,
// sweeps taps 0..N_TAPS-1 through a registered multiplier, emits one saturated output.
module fir_mac_seq #(
    parameter int WIDTH_DATA    = 8,
    parameter int WIDTH_COEF    = 8,
    parameter int N_TAPS        = 16,
    parameter int WIDTH_MAC_OUT = 8
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH_DATA-1:0]         din,
    output logic [WIDTH_DATA-1:0]         asr_d,
    output logic                          asr_en,
    output logic [$clog2(N_TAPS)-1:0]     asr_add,
    input  logic [WIDTH_DATA-1:0]         asr_q,
    output logic [$clog2(N_TAPS)-1:0]     coef_add,
    input  logic [WIDTH_COEF-1:0]         coef,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH_MAC_OUT-1:0]      dout
);
    localparam int AW  = $clog2(N_TAPS);
    localparam int PW  = WIDTH_DATA + WIDTH_COEF;
    localparam int ACW = PW + AW;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic signed [ACW-1:0] SAT_MAX = ACW'((1 << (WIDTH_MAC_OUT - 1)) - 1);
    localparam logic signed [ACW-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              state;
    logic [AW-1:0]           k;
    logic signed [ACW-1:0]   acc;
    logic signed [PW-1:0]    prod;
    logic                    prod_vld;

    logic signed [PW-1:0]    q_ext;
    logic signed [PW-1:0]    c_ext;
    logic signed [PW-1:0]    prod_next;
    logic signed [ACW-1:0]   prod_ext;
    logic signed [ACW-1:0]   acc_sum;
    logic signed [ACW-1:0]   fin_shift;
    logic [WIDTH_MAC_OUT-1:0] sat_val;
    logic                    accept;

    assign in_ready  = (state == S_IDLE) && clr;
    assign accept    = in_valid && in_ready;
    assign asr_en    = accept;
    assign asr_d     = din;
    assign asr_add   = (state == S_MAC) ? k : '0;
    assign coef_add  = asr_add;
    assign out_valid = (state == S_OUT);

    // Operands are sign-extended to full product width so the low PW bits are exact.
    assign q_ext     = {{WIDTH_COEF{asr_q[WIDTH_DATA-1]}}, asr_q};
    assign c_ext     = {{WIDTH_DATA{coef[WIDTH_COEF-1]}}, coef};
    assign prod_next = q_ext * c_ext;
    assign prod_ext  = {{AW{prod[PW-1]}}, prod};
    assign acc_sum   = acc + prod_ext;
    assign fin_shift = acc_sum >>> (WIDTH_COEF - 1);

    always_comb begin
        sat_val = fin_shift[WIDTH_MAC_OUT-1:0];
        if (fin_shift > SAT_MAX)
            sat_val = SAT_MAX[WIDTH_MAC_OUT-1:0];
        else if (fin_shift < SAT_MIN)
            sat_val = SAT_MIN[WIDTH_MAC_OUT-1:0];
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= S_IDLE;
            k        <= '0;
            acc      <= '0;
            prod     <= '0;
            prod_vld <= 1'b0;
            dout     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        acc      <= '0;
                        k        <= '0;
                        prod_vld <= 1'b0;
                        state    <= S_MAC;
                    end
                end
                S_MAC: begin
                    // Product of tap k lands one cycle later; accumulate the previous one.
                    prod     <= prod_next;
                    prod_vld <= 1'b1;
                    if (prod_vld)
                        acc <= acc_sum;
                    k <= k + 1'b1;
                    if (k == AW'(N_TAPS - 1))
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    dout     <= sat_val;
                    prod_vld <= 1'b0;
                    state    <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed + randomized bench for fir_mac_seq; a behavioural ASR stub feeds taps and a
// history-based convolution model predicts each saturated output.
module tb_fir_mac_seq;
    localparam int N = 16;

    logic              clk;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] din;
    logic signed [7:0] asr_d;
    logic              asr_en;
    logic [3:0]        asr_add;
    logic signed [7:0] asr_q;
    logic [3:0]        coef_add;
    logic signed [7:0] coef;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] dout;

    int checks = 0;
    int failures = 0;

    logic signed [7:0] h_mem [N];
    logic signed [7:0] asr_mem [N] = '{default: 8'sd0};
    int                hist [N] = '{default: 0};

    fir_mac_seq dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .din(din),
        .asr_d(asr_d), .asr_en(asr_en), .asr_add(asr_add), .asr_q(asr_q),
        .coef_add(coef_add), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
        .dout(dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Neighbouring blocks: shift register and coefficient ROM, both combinational reads.
    always @(posedge clk) begin
        if (asr_en) begin
            for (int i = N - 1; i > 0; i--) asr_mem[i] <= asr_mem[i-1];
            asr_mem[0] <= asr_d;
        end
    end
    assign asr_q = asr_mem[asr_add];
    assign coef  = h_mem[coef_add];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_y();
        int s = 0;
        for (int j = 0; j < N; j++) s += int'(h_mem[j]) * hist[j];
        s = s >>> 7;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic push_hist(input int v);
        for (int j = N - 1; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = v;
    endtask

    // Called at a negedge; returns at the negedge just after the accept edge.
    task automatic accept(input logic signed [7:0] v);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", int'(in_ready), 1);
        din = v;
        in_valid = 1'b1;
        #1;
        chk("asr_en_on_accept", int'(asr_en), 1);
        chk("asr_d_copy", int'(asr_d), int'(v));
        push_hist(int'(v));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits for out_valid, checking latency, address sweep and the result.
    task automatic collect(input string tag);
        int lat = 1;
        int en_cnt = 0;
        bit sweep_ok = 1'b1;
        int exp_y;
        exp_y = ref_y();
        while (!out_valid && lat < 40) begin
            if (asr_add !== coef_add) sweep_ok = 1'b0;
            if (lat <= N && int'(asr_add) != lat - 1) sweep_ok = 1'b0;
            if (lat > N && asr_add !== 4'd0) sweep_ok = 1'b0;
            if (asr_en) en_cnt++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, N + 2);
        chk({tag, "_dout"}, int'(dout), exp_y);
        chk({tag, "_sweep"}, int'(sweep_ok), 1);
        chk({tag, "_asr_en_once"}, en_cnt, 0);
    endtask

    task automatic run_sample(input string tag, input logic signed [7:0] v);
        accept(v);
        collect(tag);
        @(negedge clk);
        chk({tag, "_out_valid_drop"}, int'(out_valid), 0);
        chk({tag, "_in_ready_back"}, int'(in_ready), 1);
    endtask

    task automatic set_h(input int h0, input int rest);
        h_mem[0] = 8'(h0);
        for (int j = 1; j < N; j++) h_mem[j] = 8'(rest);
    endtask

    initial begin
        int ov_cnt;
        logic signed [7:0] held;
        clr = 1'b0;
        in_valid = 1'b0;
        din = '0;
        out_ready = 1'b1;
        set_h(64, 0);
        repeat (3) @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_asr_en", int'(asr_en), 0);
        chk("rst_asr_add", int'(asr_add), 0);
        chk("rst_coef_add", int'(coef_add), 0);
        clr = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);

        // Impulse
        run_sample("imp64", 8'sd64);
        chk("imp64_const", int'(dout), 32);
        run_sample("imp0", 8'sd0);
        chk("imp0_const", int'(dout), 0);

        // Accumulate into positive saturation
        set_h(16, 16);
        for (int i = 0; i < N; i++) run_sample("flush", 8'sd0);
        for (int i = 0; i < N + 2; i++) run_sample("acc", 8'sd64);
        chk("acc_sat_const", int'(dout), 127);

        // Negative saturation
        set_h(127, 127);
        for (int i = 0; i < N; i++) run_sample("neg", -8'sd128);
        chk("neg_sat_const", int'(dout), -128);

        // Truncation toward minus infinity after a fresh reset
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        set_h(1, 0);
        run_sample("trunc", -8'sd1);
        chk("trunc_const", int'(dout), -1);

        // Backpressure
        set_h(32, 8);
        out_ready = 1'b0;
        accept(8'sd100);
        collect("bp");
        held = dout;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            din = 8'($urandom);
            #1;
            chk("bp_no_asr_en", int'(asr_en), 0);
            chk("bp_in_ready_low", int'(in_ready), 0);
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_dout_stable", int'(dout), int'(held));
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_single_xfer", int'(out_valid), 0);
        chk("bp_in_ready_after", int'(in_ready), 1);
        @(negedge clk);
        chk("bp_no_second_xfer", int'(out_valid), 0);
        run_sample("bp_next", -8'sd77);

        // Reset in the middle of the tap sweep
        accept(8'sd55);
        begin
            int guard = 0;
            while (asr_add !== 4'd7 && guard < 30) begin
                @(negedge clk);
                guard++;
            end
            chk("midrst_reach_k7", int'(asr_add), 7);
        end
        clr = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_asr_add", int'(asr_add), 0);
        chk("midrst_coef_add", int'(coef_add), 0);
        chk("midrst_asr_en", int'(asr_en), 0);
        chk("midrst_dout", int'(dout), 0);
        repeat (2) @(negedge clk);
        clr = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("midrst_no_output", ov_cnt, 0);
        run_sample("midrst_next", 8'sd90);

        // Randomized coefficients and samples
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0)
                for (int j = 0; j < N; j++) h_mem[j] = 8'($urandom);
            run_sample("rand", 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
